// File: rtl/truth_table_sweeper_if.sv
// Control and result bundle between a sweep controller and the truth table sweeper.
interface truth_table_sweeper_if #(
  parameter int N_IN = 6
);
  logic                  start;
  logic                  abort;
  logic                  x_in;
  logic [N_IN-1:0]       vec;
  logic                  busy;
  logic                  done;
  logic [(1<<N_IN)-1:0]  truth_table;
  logic [N_IN:0]         ones_count;

  modport master (
    output start, abort, x_in,
    input  vec, busy, done, truth_table, ones_count
  );

  modport slave (
    input  start, abort, x_in,
    output vec, busy, done, truth_table, ones_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational device, waits a settle time per
// vector, samples its output and builds the full truth table plus a minterm count.
module truth_table_sweeper #(
  parameter int N_IN          = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam int N_VEC = 1 << N_IN;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_VEC-1:0]   tt_q, tt_d;
  logic [N_IN:0]      ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Abort wins everywhere; in SAMPLE it also suppresses the table write.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          tt_d[vec_q] = bus.x_in;
          ones_d      = ones_q + {{N_IN{1'b0}}, bus.x_in};
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = !bus.abort;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.vec         = vec_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.ones_count  = ones_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus driver and downstream response collector for a 6-input combinational device under characterisation (inputs a..f, output x).
- On `start`, walks all 2^N_IN input vectors in ascending order and waits a programmable settle time per vector.
- Samples the device output each vector and assembles the full truth table plus a count of true minterms.
- Replaces the simulation-only exhaustive loop with synthesizable on-chip hardware.

Parameters:
- N_IN, 6: number of device inputs; vector width.
- SETTLE_CYCLES, 2: clock cycles each vector is held before `x_in` is sampled; legal range ≥1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  terminate a sweep early.
- x_in  input  1  device output under test.
- vec  output  N_IN  applied input vector; vec[N_IN-1] = a, vec[0] = f.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse on sweep completion.
- truth_table  output  2^N_IN  bit i = x_in sampled while vec == i.
- ones_count  output  N_IN+1  number of set bits in truth_table.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; vec, busy, done, truth_table and ones_count all 0; settle counter = 0.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 and abort = 0 → next state SETTLE.
  - On that transition: vec ← 0, settle counter ← 0, truth_table ← 0, ones_count ← 0, busy ← 1.
  - Otherwise hold; truth_table, ones_count and vec keep the previous sweep's results.
- SETTLE:
  - If counter == SETTLE_CYCLES-1 → SAMPLE.
  - Else counter ← counter+1.
  - vec is stable throughout.
- SAMPLE, one cycle:
  - truth_table[vec] ← x_in; ones_count ← ones_count + x_in.
  - If vec == 2^N_IN-1 → DONE.
  - Else vec ← vec+1, counter ← 0, → SETTLE.
- DONE, one cycle: done = 1, busy = 0 → IDLE. vec holds 2^N_IN-1 until the next start.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - Let edge 0 be the edge that samples start. Vector i is sampled at edge (i+1)·(SETTLE_CYCLES+1).
  - done is high during the cycle after edge 2^N_IN·(SETTLE_CYCLES+1) + 1.
  - With defaults, done is asserted in the cycle following edge 193.
- done is never asserted outside DONE. It is asserted exactly once per completed sweep.
- start while busy (SETTLE/SAMPLE/DONE): ignored; no restart.
- abort in SETTLE/SAMPLE/DONE:
  - Next state IDLE, busy ← 0, done stays 0.
  - The SAMPLE write in the abort cycle is suppressed.
  - truth_table/ones_count retain the partial results; vec holds.
- abort and start together in IDLE: abort wins; no sweep starts.
- rst_n asserted mid-sweep: immediate return to reset values; partial results lost.
- ones_count cannot overflow: maximum 2^N_IN fits in N_IN+1 bits.
- x_in is treated as synchronous to clk (the device under test is combinational from vec). No synchroniser is included.

Test Plan:
1. Device model x = a & f; pulse start → done after 193 cycles; truth_table bits set exactly where vec[5] & vec[0]; ones_count = 16; vec = 63 afterwards.
2. x tied 1 → truth_table = all ones (64'hFFFF_FFFF_FFFF_FFFF), ones_count = 64. Then x tied 0 with a second start → truth_table = 0, ones_count = 0, confirming clear-on-start.
3. Cycle timing, SETTLE_CYCLES = 2: vec changes only every 3 cycles; busy high from the cycle after the start edge through SAMPLE of vector 63; done high for exactly 1 cycle.
4. Abort after vector 20 is sampled, using x = parity(vec) → busy drops next cycle; done never pulses; truth_table bits 0..20 = parity, bits 21..63 = 0; ones_count = 10.
5. Start pulsed again mid-sweep at vector 30, plus start and abort together in IDLE → neither restarts or starts a sweep; the running sweep completes normally with correct results.
6. rst_n pulsed low asynchronously (between clock edges) mid-sweep → all outputs 0 immediately; a subsequent start yields a correct full sweep.
